// File: rtl/mole_pkg.sv
// mole_pkg: shared state encoding, default geometry and hole helpers for the mole scheduler
package mole_pkg;
    localparam int          HOLES       = 9;
    localparam logic [11:0] X0_DEF      = 12'd64;
    localparam logic [11:0] Y0_DEF      = 12'd16;
    localparam logic [11:0] X_PITCH_DEF = 12'd192;
    localparam logic [11:0] Y_PITCH_DEF = 12'd160;
    localparam logic [11:0] PARK_X_DEF  = 12'd2000;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GAP  = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_HIT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } xy_t;
    function automatic xy_t hole_xy(input logic [3:0] hole, input logic [11:0] x0, y0, xp, yp);
        xy_t r;
        r.x = x0 + 12'(hole % 4'd3) * xp;
        r.y = y0 + 12'(hole / 4'd3) * yp;
        return r;
    endfunction
    function automatic logic [3:0] pick_hole(input logic [15:0] lfsr, input logic [3:0] prev);
        logic [3:0] h;
        h = (lfsr[3:0] >= 4'(HOLES)) ? lfsr[3:0] - 4'(HOLES) : lfsr[3:0];
        return (h != prev) ? h : (h == 4'(HOLES - 1)) ? 4'd0 : h + 4'd1;
    endfunction
endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 16-bit Galois LFSR, steps every clock
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= SEED;
        else        q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0);
    end
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round sequencer with frame-aligned sprite placement and scoring
module mole_scheduler
    import mole_pkg::*;
#(
    parameter logic [11:0] X0         = X0_DEF,
    parameter logic [11:0] Y0         = Y0_DEF,
    parameter logic [11:0] X_PITCH    = X_PITCH_DEF,
    parameter logic [11:0] Y_PITCH    = Y_PITCH_DEF,
    parameter logic [11:0] PARK_X     = PARK_X_DEF,
    parameter int          GAP_FRAMES = 30,
    parameter int          UP_FRAMES  = 60,
    parameter int          HIT_FRAMES = 15,
    parameter int          ROUNDS     = 20,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [8:0]  hit_key,
    output logic [11:0] x_offset,
    output logic [11:0] y_offset,
    output logic        mole_visible,
    output logic        hit_flag,
    output logic [7:0]  score,
    output logic [4:0]  round_cnt,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        busy,
    output logic        done
);
    logic [2:0]  state, nxt;
    logic [15:0] frame_cnt, lfsr;
    logic [3:0]  hole;
    logic        key_hit, gap_end, up_end, hit_end, show;
    xy_t         tgt;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .q(lfsr));

    assign key_hit = hit_key[hole];
    assign gap_end = frame_tick && frame_cnt == 16'(GAP_FRAMES - 1);
    assign up_end  = frame_tick && frame_cnt == 16'(UP_FRAMES - 1);
    assign hit_end = frame_tick && frame_cnt == 16'(HIT_FRAMES - 1);
    assign show    = state == S_UP || state == S_HIT;
    assign tgt     = hole_xy(hole, X0, Y0, X_PITCH, Y_PITCH);
    assign busy    = state == S_GAP || show;
    assign done    = state == S_DONE;

    // a correct key beats a coinciding timeout tick
    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE, S_DONE: nxt = start ? S_GAP : state;
            S_GAP:          nxt = gap_end ? S_UP : S_GAP;
            S_UP:           nxt = key_hit ? S_HIT : !up_end ? S_UP :
                                  (round_cnt == 5'(ROUNDS - 1)) ? S_DONE : S_GAP;
            S_HIT:          nxt = !hit_end ? S_HIT : (round_cnt == 5'(ROUNDS)) ? S_DONE : S_GAP;
            default:        nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            frame_cnt    <= 16'd0;
            hole         <= 4'd0;
            score        <= 8'd0;
            round_cnt    <= 5'd0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            x_offset     <= PARK_X;
            y_offset     <= 12'd0;
            mole_visible <= 1'b0;
            hit_flag     <= 1'b0;
        end else begin
            state      <= nxt;
            frame_cnt  <= (nxt != state) ? 16'd0 : frame_cnt + {15'd0, frame_tick};
            hit_pulse  <= state == S_UP && key_hit;
            miss_pulse <= state == S_UP && !key_hit && up_end;
            if (state == S_GAP && nxt == S_UP) hole <= pick_hole(lfsr, hole);
            if (state == S_UP && nxt != S_UP) round_cnt <= round_cnt + 5'd1;
            if (state == S_UP && key_hit && score != 8'hFF) score <= score + 8'd1;
            if (state == S_DONE && start) begin
                score     <= 8'd0;
                round_cnt <= 5'd0;
            end
            if (frame_tick) begin
                x_offset     <= show ? tgt.x : PARK_X;
                y_offset     <= show ? tgt.y : 12'd0;
                mole_visible <= show;
                hit_flag     <= state == S_HIT;
            end
        end
    end
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: table vectors, randomized play against a reference model, and reset corner cases
module tb_mole_scheduler;
    localparam int GAP = 2, UP = 3, HIT = 1, ROUNDS = 3;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, frame_tick = 1'b0;
    logic [8:0]  hit_key = 9'd0;
    logic [11:0] x_offset, y_offset;
    logic        mole_visible, hit_flag, hit_pulse, miss_pulse, busy, done;
    logic [7:0]  score;
    logic [4:0]  round_cnt;

    int errors = 0, checks = 0;

    mole_scheduler #(.GAP_FRAMES(GAP), .UP_FRAMES(UP), .HIT_FRAMES(HIT), .ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_tick(frame_tick), .hit_key(hit_key),
        .x_offset(x_offset), .y_offset(y_offset), .mole_visible(mole_visible), .hit_flag(hit_flag),
        .score(score), .round_cnt(round_cnt), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef enum {P_IDLE, P_GAP, P_UP, P_HIT, P_DONE} phase_t;
    phase_t ph;
    int left, m_hole, lf, ex, ey, esc, ernd;
    bit ev, ehf, ehp, emp;
    int prev_obs = -1, rounds_obs = 0;
    bit last_vis = 1'b0;

    typedef struct {
        logic s, ft;
        int   km;
        logic vis, hf, hp, mp;
        int   sc, rnd;
        logic bsy, dn;
    } vec_t;

    vec_t tbl [25] = '{
        '{0,1,0, 0,0,0,0, 0,0, 0,0}, '{0,0,0, 0,0,0,0, 0,0, 0,0}, '{1,1,0, 0,0,0,0, 0,0, 1,0},
        '{0,1,0, 0,0,0,0, 0,0, 1,0}, '{0,0,3, 0,0,0,0, 0,0, 1,0}, '{0,1,0, 0,0,0,0, 0,0, 1,0},
        '{0,1,0, 1,0,0,0, 0,0, 1,0}, '{0,0,2, 1,0,0,0, 0,0, 1,0}, '{0,1,0, 1,0,0,0, 0,0, 1,0},
        '{0,1,0, 1,0,0,1, 0,1, 1,0}, '{0,0,0, 1,0,0,0, 0,1, 1,0}, '{0,1,0, 0,0,0,0, 0,1, 1,0},
        '{0,1,0, 0,0,0,0, 0,1, 1,0}, '{0,0,1, 0,0,1,0, 1,2, 1,0}, '{0,0,0, 0,0,0,0, 1,2, 1,0},
        '{0,1,0, 1,1,0,0, 1,2, 1,0}, '{0,1,0, 0,0,0,0, 1,2, 1,0}, '{0,1,0, 0,0,0,0, 1,2, 1,0},
        '{0,1,0, 1,0,0,0, 1,2, 1,0}, '{0,1,0, 1,0,0,0, 1,2, 1,0}, '{0,1,1, 1,0,1,0, 2,3, 1,0},
        '{0,1,0, 1,1,0,0, 2,3, 0,1}, '{0,1,0, 0,0,0,0, 2,3, 0,1}, '{0,0,3, 0,0,0,0, 2,3, 0,1},
        '{1,0,0, 0,0,0,0, 0,0, 1,0}
    };

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE; left = 0; m_hole = 0; lf = 'hACE1;
        ex = 2000; ey = 0; ev = 0; ehf = 0; ehp = 0; emp = 0; esc = 0; ernd = 0;
    endtask

    task automatic model_step();
        int h;
        ehp = 0;
        emp = 0;
        if (frame_tick) begin
            ev  = (ph == P_UP || ph == P_HIT);
            ehf = (ph == P_HIT);
            ex  = ev ? 64 + (m_hole % 3) * 192 : 2000;
            ey  = ev ? 16 + (m_hole / 3) * 160 : 0;
        end
        case (ph)
            P_IDLE: if (start) begin ph = P_GAP; left = GAP; end
            P_DONE: if (start) begin ph = P_GAP; left = GAP; esc = 0; ernd = 0; end
            P_GAP: if (frame_tick) begin
                left--;
                if (left == 0) begin
                    h = (lf % 16) % 9;
                    m_hole = (h == m_hole) ? (h + 1) % 9 : h;
                    ph = P_UP;
                    left = UP;
                end
            end
            P_UP: if (hit_key[m_hole]) begin
                ehp = 1; esc = (esc < 255) ? esc + 1 : 255; ernd++; ph = P_HIT; left = HIT;
            end else if (frame_tick) begin
                left--;
                if (left == 0) begin
                    emp = 1; ernd++; ph = (ernd == ROUNDS) ? P_DONE : P_GAP; left = GAP;
                end
            end
            P_HIT: if (frame_tick) begin
                left--;
                if (left == 0) begin ph = (ernd == ROUNDS) ? P_DONE : P_GAP; left = GAP; end
            end
            default: ;
        endcase
        lf = (lf & 1) ? ((lf >> 1) ^ 'hB400) : (lf >> 1);
    endtask

    task automatic check_all();
        chk("x_offset", x_offset, ex);
        chk("y_offset", y_offset, ey);
        chk("mole_visible", mole_visible, ev);
        chk("hit_flag", hit_flag, ehf);
        chk("hit_pulse", hit_pulse, ehp);
        chk("miss_pulse", miss_pulse, emp);
        chk("score", score, esc);
        chk("round_cnt", round_cnt, ernd);
        chk("busy", busy, int'(ph == P_GAP || ph == P_UP || ph == P_HIT));
        chk("done", done, int'(ph == P_DONE));
    endtask

    // each newly shown mole must sit on the grid and differ from the previous round's hole
    task automatic observe();
        int dx, dy, hole;
        if (mole_visible && !last_vis) begin
            dx = int'(x_offset) - 64;
            dy = int'(y_offset) - 16;
            hole = (dy / 160) * 3 + dx / 192;
            chk("hole_on_grid", int'(dx >= 0 && dy >= 0 && dx % 192 == 0 && dy % 160 == 0
                                     && dx / 192 < 3 && dy / 160 < 3), 1);
            chk("hole_no_repeat", int'(hole != prev_obs), 1);
            prev_obs = hole;
            rounds_obs++;
        end
        last_vis = mole_visible;
    endtask

    function automatic logic [8:0] key_of(input int km);
        logic [8:0] one = 9'd1;
        case (km)
            1: return one << m_hole;
            2: return one << ((m_hole + 1 + int'($urandom_range(0, 7))) % 9);
            3: return 9'h1FF;
            default: return 9'd0;
        endcase
    endfunction

    task automatic cycle(input logic s, input logic ft, input logic [8:0] k);
        start = s;
        frame_tick = ft;
        hit_key = k;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        observe();
    endtask

    initial begin
        int r;
        bit reached;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'(i % 2), 9'h1FF);
        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].s, tbl[i].ft, key_of(tbl[i].km));
            chk($sformatf("vec%0d_vis", i), mole_visible, tbl[i].vis);
            chk($sformatf("vec%0d_hf", i), hit_flag, tbl[i].hf);
            chk($sformatf("vec%0d_hp", i), hit_pulse, tbl[i].hp);
            chk($sformatf("vec%0d_mp", i), miss_pulse, tbl[i].mp);
            chk($sformatf("vec%0d_score", i), score, tbl[i].sc);
            chk($sformatf("vec%0d_round", i), round_cnt, tbl[i].rnd);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("vec%0d_done", i), done, tbl[i].dn);
        end
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 9);
            cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0),
                  key_of(r < 2 ? 1 : r == 2 ? 2 : r == 3 ? 3 : 0));
        end
        chk("rounds_seen_ge_50", int'(rounds_obs >= 50), 1);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            cycle(1'(ph == P_IDLE || ph == P_DONE), 1'b1, 9'd0);
            reached = (ph == P_UP && mole_visible);
        end
        chk("reach_up_visible", int'(reached), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_x", x_offset, 2000);
        chk("rst_y", y_offset, 0);
        chk("rst_vis", mole_visible, 0);
        chk("rst_busy", busy, 0);
        chk("rst_score", score, 0);
        chk("rst_round", round_cnt, 0);
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_obs = -1;
        last_vis = 1'b0;
        for (int i = 0; i < 40; i++) cycle(1'(i == 0), 1'(i % 2), key_of(i % 5 == 0 ? 1 : 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
